// File: rtl/snake_step_ctrl.sv
// Snake body/movement engine: steps the head one cell per frame tick with toroidal wrap,
// grows on request, then scans the body one segment per cycle for a self-hit.
module snake_step_ctrl #(
  parameter int GRID_W   = 32,
  parameter int GRID_H   = 24,
  parameter int COORD_W  = 6,
  parameter int MAX_LEN  = 16,
  parameter int LEN_W    = 5,
  parameter int INIT_X   = 16,
  parameter int INIT_Y   = 12,
  parameter int INIT_LEN = 3
) (
  input  logic               clock,
  input  logic               resetn,
  input  logic               tick,
  input  logic [1:0]         dir_req,
  input  logic               dir_valid,
  input  logic               grow,
  input  logic [LEN_W-1:0]   rd_idx,
  output logic [COORD_W-1:0] rd_x,
  output logic [COORD_W-1:0] rd_y,
  output logic               rd_valid,
  output logic [COORD_W-1:0] head_x,
  output logic [COORD_W-1:0] head_y,
  output logic [LEN_W-1:0]   len,
  output logic               step_done,
  output logic               game_over
);

  // state | meaning
  // RUN   | idle, waiting for a frame tick
  // SHIFT | move body down one slot, write new head, apply growth
  // CHECK | compare body[idx] against the head, one segment per cycle
  // DEAD  | self-hit seen; frozen until reset
  typedef enum logic [1:0] {S_RUN, S_SHIFT, S_CHECK, S_DEAD} state_t;

  localparam int IDX_W = $clog2(MAX_LEN);

  state_t             r_state, w_state_nxt;
  logic [COORD_W-1:0] r_body_x [MAX_LEN];
  logic [COORD_W-1:0] r_body_y [MAX_LEN];
  logic [1:0]         r_cur_dir, r_pend_dir;
  logic               r_grow_pend;
  logic [LEN_W-1:0]   r_len, r_idx;
  logic               r_step_done, r_game_over;
  logic [COORD_W-1:0] r_rd_x, r_rd_y;
  logic               r_rd_valid;

  logic [COORD_W-1:0] w_nx, w_ny;
  logic [IDX_W-1:0]   w_idx, w_rd_sel;
  logic               w_hit, w_last, w_rd_in_range, w_dir_acc;
  logic [1:0]         w_dir_ref;

  assign w_idx         = r_idx[IDX_W-1:0];
  assign w_rd_sel      = rd_idx[IDX_W-1:0];
  assign w_rd_in_range = rd_idx < LEN_W'(MAX_LEN);
  assign w_hit  = (r_body_x[w_idx] == r_body_x[0]) && (r_body_y[w_idx] == r_body_y[0]);
  assign w_last = r_idx == (r_len - LEN_W'(1));

  // During SHIFT the pending direction becomes current, so reversal is judged against it.
  assign w_dir_ref = (r_state == S_SHIFT) ? r_pend_dir : r_cur_dir;
  assign w_dir_acc = dir_valid && (dir_req != (w_dir_ref ^ 2'b10));

  always_comb begin
    w_nx = r_body_x[0];
    w_ny = r_body_y[0];
    case (r_pend_dir)
      2'b00: w_ny = (r_body_y[0] == '0) ? COORD_W'(GRID_H-1) : r_body_y[0] - COORD_W'(1);
      2'b01: w_nx = (r_body_x[0] == COORD_W'(GRID_W-1)) ? '0 : r_body_x[0] + COORD_W'(1);
      2'b10: w_ny = (r_body_y[0] == COORD_W'(GRID_H-1)) ? '0 : r_body_y[0] + COORD_W'(1);
      default: w_nx = (r_body_x[0] == '0) ? COORD_W'(GRID_W-1) : r_body_x[0] - COORD_W'(1);
    endcase
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_RUN:   if (tick) w_state_nxt = S_SHIFT;
      S_SHIFT: w_state_nxt = S_CHECK;
      S_CHECK: begin
        if (w_hit)       w_state_nxt = S_DEAD;
        else if (w_last) w_state_nxt = S_RUN;
      end
      default: w_state_nxt = S_DEAD;
    endcase
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) r_state <= S_RUN;
    else         r_state <= w_state_nxt;
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      for (int i = 0; i < MAX_LEN; i++) begin
        r_body_x[i] <= COORD_W'(INIT_X - i);
        r_body_y[i] <= COORD_W'(INIT_Y);
      end
      r_cur_dir   <= 2'b01;
      r_pend_dir  <= 2'b01;
      r_grow_pend <= 1'b0;
      r_len       <= LEN_W'(INIT_LEN);
      r_idx       <= '0;
      r_step_done <= 1'b0;
      r_game_over <= 1'b0;
      r_rd_x      <= '0;
      r_rd_y      <= '0;
      r_rd_valid  <= 1'b0;
    end else begin
      r_step_done <= 1'b0;
      r_rd_valid  <= rd_idx < r_len;
      r_rd_x      <= w_rd_in_range ? r_body_x[w_rd_sel] : '0;
      r_rd_y      <= w_rd_in_range ? r_body_y[w_rd_sel] : '0;
      if (r_state != S_DEAD && w_dir_acc) r_pend_dir  <= dir_req;
      if (r_state != S_DEAD && grow)      r_grow_pend <= 1'b1;
      case (r_state)
        S_SHIFT: begin
          for (int i = 1; i < MAX_LEN; i++) begin
            r_body_x[i] <= r_body_x[i-1];
            r_body_y[i] <= r_body_y[i-1];
          end
          r_body_x[0] <= w_nx;
          r_body_y[0] <= w_ny;
          r_cur_dir   <= r_pend_dir;
          // Growth simply keeps the shifted-down old tail inside the length.
          if (r_grow_pend && r_len < LEN_W'(MAX_LEN)) r_len <= r_len + LEN_W'(1);
          r_grow_pend <= grow;
          r_idx       <= LEN_W'(1);
        end
        S_CHECK: begin
          if (w_hit)       r_game_over <= 1'b1;
          else if (w_last) r_step_done <= 1'b1;
          else             r_idx       <= r_idx + LEN_W'(1);
        end
        default: ;
      endcase
    end
  end

  assign head_x    = r_body_x[0];
  assign head_y    = r_body_y[0];
  assign len       = r_len;
  assign step_done = r_step_done;
  assign game_over = r_game_over;
  assign rd_x      = r_rd_x;
  assign rd_y      = r_rd_y;
  assign rd_valid  = r_rd_valid;

endmodule
